// File: rtl/cla_pkg.sv
// Shared constants and 4-bit carry-lookahead cell functions for the pipelined adder/subtractor.
package cla_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int GROUP     = 16;
  localparam int WORD_BIT  = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t cla4_gp(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] g;
    logic [3:0] p;
    gp_t        r;
    g   = x & y;
    p   = x ^ y;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

  function automatic logic [3:0] cla4_sum(input logic [3:0] x, input logic [3:0] y,
                                          input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

endpackage

// File: rtl/cla16_gp.sv
// 16-bit lookahead group: four 4-bit CLA cells with a second lookahead level,
// exporting group generate/propagate for the inter-group carry chain.
module cla16_gp
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [3:0] ng;
  logic [3:0] np;
  logic [3:0] nc;
  gp_t        t;

  always_comb begin
    ng = '0;
    np = '0;
    t  = '0;
    for (int i = 0; i < 4; i++) begin
      t     = cla4_gp(a[4*i +: 4], b[4*i +: 4]);
      ng[i] = t.g;
      np[i] = t.p;
    end
  end

  always_comb begin
    nc[0] = cin;
    nc[1] = ng[0] | (np[0] & cin);
    nc[2] = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & cin);
    nc[3] = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0]) | (np[2] & np[1] & np[0] & cin);
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      sum[4*i +: 4] = cla4_sum(a[4*i +: 4], b[4*i +: 4], nc[i]);
    end
  end

  assign g = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1]) | (np[3] & np[2] & np[1] & ng[0]);
  assign p = &np;

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead add/subtract: one operand segment per register stage,
// valid/ready handshake with whole-pipe stall and bubble collapsing.
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int GPS = SEG / GROUP;
  localparam int NG  = WIDTH / GROUP;
  localparam int L   = STAGES - 1;

  logic [STAGES-1:0] v_q, c_q, w_q, en;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [STAGES-1:0] src_v, src_c, src_w;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  wire  [WIDTH-1:0]  sum_all;
  wire  [STAGES-1:0] seg_co;

  logic [WIDTH-1:0]  s_fin;
  logic              cout_fin, ovf_fin;

  assign out_valid = v_q[L];
  assign in_ready  = rst | ~v_q[L] | out_ready;

  // Stage 0 sees the inverted subtrahend and the +1 as its carry-in.
  always_comb begin
    src_v[0] = in_valid & in_ready & ~rst;
    src_a[0] = a;
    src_b[0] = b ^ {WIDTH{sub}};
    src_s[0] = '0;
    src_c[0] = sub;
    src_w[0] = word;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_w[k] = w_q[k-1];
    end
  end

  for (genvar j = 0; j < NG; j++) begin : grp
    localparam int K = j / GPS;
    logic ci, gg, gp, co;
    if (j % GPS == 0) begin : g_cin_stage
      assign ci = src_c[K];
    end else begin : g_cin_chain
      assign ci = grp[j-1].co;
    end
    cla16_gp u_cla (
      .a   (src_a[K][GROUP*j +: GROUP]),
      .b   (src_b[K][GROUP*j +: GROUP]),
      .cin (ci),
      .sum (sum_all[GROUP*j +: GROUP]),
      .g   (gg),
      .p   (gp)
    );
    assign co = gg | (gp & ci);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg_co
    assign seg_co[k] = grp[(k+1)*GPS-1].co;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k]               = src_s[k];
      nxt_s[k][k*SEG +: SEG] = sum_all[k*SEG +: SEG];
    end
  end

  // A stage may load whenever it is empty or its content moves on.
  always_comb begin
    en    = '0;
    en[L] = ~v_q[L] | out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      en[k] = ~v_q[k] | en[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      w_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= nxt_s[k];
            c_q[k] <= seg_co[k];
            w_q[k] <= src_w[k];
          end
        end
      end
    end
  end

  if (WIDTH > WORD_BIT) begin : g_word
    // Carry into bit 32 is recovered from the full-width sum bit.
    always_comb begin
      if (w_q[L]) begin
        s_fin    = {{(WIDTH-WORD_BIT){s_q[L][WORD_BIT-1]}}, s_q[L][WORD_BIT-1:0]};
        cout_fin = s_q[L][WORD_BIT] ^ a_q[L][WORD_BIT] ^ b_q[L][WORD_BIT];
        ovf_fin  = (a_q[L][WORD_BIT-1] == b_q[L][WORD_BIT-1]) &
                   (s_q[L][WORD_BIT-1] != a_q[L][WORD_BIT-1]);
      end else begin
        s_fin    = s_q[L];
        cout_fin = c_q[L];
        ovf_fin  = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
      end
    end
  end else begin : g_noword
    always_comb begin
      s_fin    = s_q[L];
      cout_fin = c_q[L];
      ovf_fin  = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
    end
  end

  assign s    = s_fin;
  assign cout = cout_fin;
  assign ovf  = ovf_fin;
  assign zero = v_q[L] & (s_fin == '0);

endmodule
